// File: rtl/tm1638_source_mux.sv
// Registered N-channel frame selector feeding tm1638_driver. It keeps a shadow
// of the last frame from every channel, so a source switch refreshes the display at once.
module tm1638_source_mux #(
  parameter  int NUM_CH      = 8,
  parameter  int SEG_W       = 64,
  parameter  int LED_W       = 8,
  parameter  int AUTO_CYCLES = 0,
  localparam int SEL_W       = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [NUM_CH*SEG_W-1:0] i_Ch_Segments,
  input  logic [NUM_CH*LED_W-1:0] i_Ch_Leds,
  input  logic [NUM_CH-1:0]       i_Ch_Valid,
  input  logic                    i_Next,
  input  logic                    i_Prev,
  input  logic                    i_Auto_En,
  input  logic                    i_Ready,
  output logic [SEG_W-1:0]        o_Segments,
  output logic [LED_W-1:0]        o_Leds,
  output logic                    o_Valid,
  output logic [SEL_W-1:0]        o_Sel,
  output logic                    o_Sel_Changed
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

  logic             auto_tick;
  logic             step_up;
  logic             step_dn;
  logic [SEG_W-1:0] shadow_seg [NUM_CH];
  logic [LED_W-1:0] shadow_led [NUM_CH];
  logic [NUM_CH-1:0] shadow_valid;
  logic [SEG_W-1:0] live_seg;
  logic [LED_W-1:0] live_led;
  logic             live_valid;

  generate
    if (AUTO_CYCLES > 0) begin : g_auto
      localparam int CNT_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_CYCLES - 1);
      logic [CNT_W-1:0] auto_cnt;

      assign auto_tick = i_Auto_En && (auto_cnt == CNT_LAST);

      // Any manual step restarts the rotation period.
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge i_Clk) begin
        if (i_Rst || !i_Auto_En || i_Next || i_Prev || auto_tick)
          auto_cnt <= '0;
        else
          auto_cnt <= auto_cnt + 1'b1;
      end
    end else begin : g_no_auto
      assign auto_tick = 1'b0;
    end
  endgenerate

  // A manual step overrides a coincident tick; Next+Prev together cancel both.
  assign step_up = (i_Next && !i_Prev) || (auto_tick && !i_Next && !i_Prev);
  assign step_dn = i_Prev && !i_Next;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Sel         <= '0;
      o_Sel_Changed <= 1'b0;
    end else begin
      o_Sel_Changed <= step_up || step_dn;
      if (step_up)
        o_Sel <= (o_Sel == SEL_LAST) ? '0 : o_Sel + 1'b1;
      else if (step_dn)
        o_Sel <= (o_Sel == '0) ? SEL_LAST : o_Sel - 1'b1;
    end
  end

  // NOTE: the shadow array is cleared in reset like any other state, so it must stay in flops, not a RAM.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      shadow_valid <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_seg[k] <= '0;
        shadow_led[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_Ch_Valid[k]) begin
          shadow_seg[k]   <= i_Ch_Segments[k*SEG_W +: SEG_W];
          shadow_led[k]   <= i_Ch_Leds[k*LED_W +: LED_W];
          shadow_valid[k] <= 1'b1;
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    live_seg   = i_Ch_Segments[o_Sel*SEG_W +: SEG_W];
    live_led   = i_Ch_Leds[o_Sel*LED_W +: LED_W];
    live_valid = i_Ch_Valid[o_Sel];
  end

  // On the first cycle of a new channel, any frame still pending from the old one is dropped.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Segments <= '0;
      o_Leds     <= '0;
      o_Valid    <= 1'b0;
    end else if (o_Sel_Changed) begin
      if (live_valid) begin
        o_Segments <= live_seg;
        o_Leds     <= live_led;
        o_Valid    <= 1'b1;
      end else if (shadow_valid[o_Sel]) begin
        o_Segments <= shadow_seg[o_Sel];
        o_Leds     <= shadow_led[o_Sel];
        o_Valid    <= 1'b1;
      end else begin
        o_Valid    <= 1'b0;
      end
    end else if (live_valid) begin
      o_Segments <= live_seg;
      o_Leds     <= live_led;
      o_Valid    <= 1'b1;
    end else if (o_Valid && i_Ready) begin
      o_Valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tm1638_source_mux.sv
// Directed bench for tm1638_source_mux (8 channels, auto-rotate every 4 cycles).
// Inputs change 1 ns after a rising edge, and outputs are compared at the same point.
module tb_tm1638_source_mux;

  localparam int NUM_CH = 8;
  localparam int SEG_W  = 64;
  localparam int LED_W  = 8;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH*SEG_W-1:0] ch_seg;
  logic [NUM_CH*LED_W-1:0] ch_led;
  logic [NUM_CH-1:0]       ch_valid;
  logic                    nxt, prv, auto_en, ready;
  logic [SEG_W-1:0]        seg;
  logic [LED_W-1:0]        leds;
  logic                    valid;
  logic [SEL_W-1:0]        sel;
  logic                    sel_chg;

  int checks = 0;
  int errors = 0;

  tm1638_source_mux #(
    .NUM_CH(NUM_CH), .SEG_W(SEG_W), .LED_W(LED_W), .AUTO_CYCLES(4)
  ) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Ch_Segments(ch_seg), .i_Ch_Leds(ch_led), .i_Ch_Valid(ch_valid),
    .i_Next(nxt), .i_Prev(prv), .i_Auto_En(auto_en), .i_Ready(ready),
    .o_Segments(seg), .o_Leds(leds), .o_Valid(valid),
    .o_Sel(sel), .o_Sel_Changed(sel_chg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [SEG_W-1:0] s, input logic [LED_W-1:0] l);
    ch_seg[k*SEG_W +: SEG_W] = s;
    ch_led[k*LED_W +: LED_W] = l;
  endtask

  task automatic strobe(input logic [NUM_CH-1:0] mask);
    ch_valid = mask;
    step();
    ch_valid = '0;
  endtask

  task automatic pulse_next();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
  endtask

  task automatic pulse_prev();
    prv = 1'b1;
    step();
    prv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_seg = '0; ch_led = '0; ch_valid = '0;
    nxt = 1'b0; prv = 1'b0; auto_en = 1'b0; ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if ({seg, leds, valid, sel, sel_chg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got seg=%h leds=%h v=%b sel=%0d chg=%b, expected all 0",
               seg, leds, valid, sel, sel_chg);
    end
    set_ch(0, 64'h3F, 8'h80);
    strobe(8'b0000_0001);
    checks++;
    if (valid !== 1'b1 || seg !== 64'h3F || leds !== 8'h80 || sel !== 3'd0) begin
      errors++;
      $display("FAIL first_frame: got v=%b seg=%h leds=%h sel=%0d, expected v=1 seg=3f leds=80 sel=0",
               valid, seg, leds, sel);
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL first_frame_one_cycle: got v=%b, expected 0", valid);
    end
  endtask

  task automatic test_wrap();
    pulse_prev();
    checks++;
    if (sel !== 3'd7 || sel_chg !== 1'b1) begin
      errors++;
      $display("FAIL prev_wrap: got sel=%0d chg=%b, expected sel=7 chg=1", sel, sel_chg);
    end
    step();
    checks++;
    if (sel_chg !== 1'b0) begin
      errors++;
      $display("FAIL chg_one_cycle: got chg=%b, expected 0", sel_chg);
    end
    pulse_next();
    checks++;
    if (sel !== 3'd0 || sel_chg !== 1'b1) begin
      errors++;
      $display("FAIL next_wrap: got sel=%0d chg=%b, expected sel=0 chg=1", sel, sel_chg);
    end
    step();
    nxt = 1'b1; prv = 1'b1;
    step();
    nxt = 1'b0; prv = 1'b0;
    checks++;
    if (sel !== 3'd0 || sel_chg !== 1'b0) begin
      errors++;
      $display("FAIL next_prev_cancel: got sel=%0d chg=%b, expected sel=0 chg=0", sel, sel_chg);
    end
  endtask

  task automatic test_shadow();
    set_ch(3, 64'h4F, 8'h06);
    strobe(8'b0000_1000);
    checks++;
    if (valid !== 1'b0 || seg !== 64'h3F) begin
      errors++;
      $display("FAIL unselected_strobe: got v=%b seg=%h, expected v=0 seg=3f", valid, seg);
    end
    pulse_next(); pulse_next(); pulse_next();
    checks++;
    if (sel !== 3'd3 || valid !== 1'b0) begin
      errors++;
      $display("FAIL step_to_3: got sel=%0d v=%b, expected sel=3 v=0", sel, valid);
    end
    step();
    checks++;
    if (valid !== 1'b1 || seg !== 64'h4F || leds !== 8'h06) begin
      errors++;
      $display("FAIL shadow_refresh: got v=%b seg=%h leds=%h, expected v=1 seg=4f leds=06",
               valid, seg, leds);
    end
    pulse_next();
    step();
    checks++;
    if (sel !== 3'd4 || valid !== 1'b0 || seg !== 64'h4F) begin
      errors++;
      $display("FAIL empty_channel: got sel=%0d v=%b seg=%h, expected sel=4 v=0 seg=4f",
               sel, valid, seg);
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    set_ch(4, 64'hAAAA, 8'h01);
    strobe(8'b0001_0000);
    set_ch(4, 64'hBBBB, 8'h02);
    strobe(8'b0001_0000);
    step();
    checks++;
    if (valid !== 1'b1 || seg !== 64'hBBBB || leds !== 8'h02) begin
      errors++;
      $display("FAIL latest_wins: got v=%b seg=%h leds=%h, expected v=1 seg=bbbb leds=02",
               valid, seg, leds);
    end
    ready = 1'b1;
    step();
    checks++;
    if (valid !== 1'b0 || seg !== 64'hBBBB) begin
      errors++;
      $display("FAIL single_transfer: got v=%b seg=%h, expected v=0 seg=bbbb", valid, seg);
    end
    ready = 1'b0;
    set_ch(4, 64'hDDDD, 8'h04);
    strobe(8'b0001_0000);
    ready = 1'b1;
    set_ch(4, 64'hEEEE, 8'h05);
    strobe(8'b0001_0000);
    checks++;
    if (valid !== 1'b1 || seg !== 64'hEEEE || leds !== 8'h05) begin
      errors++;
      $display("FAIL load_during_transfer: got v=%b seg=%h leds=%h, expected v=1 seg=eeee leds=05",
               valid, seg, leds);
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL transfer_after_load: got v=%b, expected 0", valid);
    end
  endtask

  task automatic test_auto();
    logic [SEL_W-1:0] exp_sel;
    auto_en = 1'b1;
    exp_sel = 3'd4;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n % 4 == 0) exp_sel = exp_sel + 3'd1;
      checks++;
      if (sel !== exp_sel) begin
        errors++;
        $display("FAIL auto_step cycle %0d: got sel=%0d, expected %0d", n, sel, exp_sel);
      end
    end
    step(); step(); step();
    pulse_next();
    checks++;
    if (sel !== 3'd7) begin
      errors++;
      $display("FAIL next_with_tick: got sel=%0d, expected 7", sel);
    end
    step(); step(); step();
    checks++;
    if (sel !== 3'd7) begin
      errors++;
      $display("FAIL auto_restart_hold: got sel=%0d, expected 7", sel);
    end
    step();
    checks++;
    if (sel !== 3'd0 || sel_chg !== 1'b1) begin
      errors++;
      $display("FAIL auto_restart_step: got sel=%0d chg=%b, expected sel=0 chg=1", sel, sel_chg);
    end
    auto_en = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    pulse_next();
    step();
    ready = 1'b0;
    set_ch(1, 64'h5555, 8'h11);
    set_ch(2, 64'h6666, 8'h22);
    strobe(8'b0000_0110);
    checks++;
    if (valid !== 1'b1 || sel !== 3'd1 || seg !== 64'h5555) begin
      errors++;
      $display("FAIL pre_reset_frame: got v=%b sel=%0d seg=%h, expected v=1 sel=1 seg=5555",
               valid, sel, seg);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({seg, leds, valid, sel, sel_chg} !== '0) begin
      errors++;
      $display("FAIL midflight_reset: got seg=%h leds=%h v=%b sel=%0d chg=%b, expected all 0",
               seg, leds, valid, sel, sel_chg);
    end
    pulse_next(); pulse_next();
    step();
    checks++;
    if (sel !== 3'd2 || valid !== 1'b0) begin
      errors++;
      $display("FAIL shadow_cleared: got sel=%0d v=%b, expected sel=2 v=0", sel, valid);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_shadow();
    test_backpressure();
    test_auto();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tm1638_source_mux.md
Name: tm1638_source_mux

Overview:
- Parametrised N-channel display-source selector for the TM1638 path. Sits between the stimulus/source generators and tm1638_driver.
- Replaces the fixed 8-way combinational select with a registered selector:
  - per-channel frame shadowing,
  - next/prev stepping and optional auto-rotation,
  - immediate refresh of the display on a source switch,
  - a valid/ready output handshake that does not lose frames.

Parameters:
- NUM_CH, 8, number of source channels (>=2).
- SEG_W, 64, frame segment bus width per channel.
- LED_W, 8, LED bus width per channel.
- AUTO_CYCLES, 0, clock cycles per auto-rotate step. 0 removes auto mode and i_Auto_En is ignored.
- Derived: SEL_W = max(1, clog2(NUM_CH)).

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  reset, synchronous, active-high
- i_Ch_Segments  in  NUM_CH*SEG_W  channel k segments at [k*SEG_W +: SEG_W]
- i_Ch_Leds  in  NUM_CH*LED_W  channel k LEDs at [k*LED_W +: LED_W]
- i_Ch_Valid  in  NUM_CH  1-cycle frame strobe per channel
- i_Next  in  1  1-cycle pulse, step selection +1
- i_Prev  in  1  1-cycle pulse, step selection -1
- i_Auto_En  in  1  level, enables auto-rotation
- i_Ready  in  1  downstream accepts the frame this cycle
- o_Segments  out  SEG_W  registered frame segments
- o_Leds  out  LED_W  registered frame LEDs
- o_Valid  out  1  frame pending
- o_Sel  out  SEL_W  current channel index
- o_Sel_Changed  out  1  1-cycle pulse when o_Sel updates

Behaviour:
- Reset values:
  - All outputs are 0.
  - Shadow registers are 0, shadow_valid[] is 0, auto counter is 0, change flag is 0.
  - Reset mid-transfer drops any pending frame.
- Shadows:
  - When i_Ch_Valid[k] is high, the shadow for channel k captures that channel's segments and LEDs, and shadow_valid[k] is set to 1.
  - This happens for every channel, selected or not.
- Selection step, sampled at cycle t, r_Sel updates at t+1:
  - i_Next alone: Sel = (Sel==NUM_CH-1) ? 0 : Sel+1.
  - i_Prev alone: Sel = (Sel==0) ? NUM_CH-1 : Sel-1.
  - i_Next and i_Prev together: no change and no pulse.
- Auto mode (AUTO_CYCLES>0 and i_Auto_En=1):
  - The counter runs from 0 to AUTO_CYCLES-1. At terminal count it produces a tick that acts like i_Next, and the counter returns to 0.
  - The counter clears on any i_Next/i_Prev, and while i_Auto_En=0.
  - Manual input in the same cycle as a tick: the manual step wins and the tick is discarded, so there is never a double step.
- o_Sel_Changed pulses in the same cycle that o_Sel takes its new value (t+1).
- Output stage, evaluated every cycle with s = r_Sel:
  - If o_Sel_Changed is high (first cycle on the new channel):
    - load the live frame if i_Ch_Valid[s];
    - otherwise load the shadow if shadow_valid[s];
    - otherwise clear o_Valid and hold the data.
    - Any frame still pending from the old channel is discarded.
  - Otherwise, if i_Ch_Valid[s]: load the live frame and set o_Valid (latency 1 cycle). A pending frame is overwritten (latest wins).
  - Otherwise, if o_Valid && i_Ready: clear o_Valid and hold the data.
  - A new load in the same cycle as a transfer keeps o_Valid=1 with the new data.
- Strobes on unselected channels only update shadows and never change the outputs.
- i_Ready is ignored while o_Valid=0. o_Segments/o_Leds are stable while o_Valid=1 and no load occurs.
- Switch-to-display latency: a step at t updates o_Sel at t+1, and o_Valid with the new channel's frame appears at t+2.

Test Plan:
1. Reset, then i_Ch_Valid[0] pulses with segments=64'h3F and leds=8'h80, i_Ready=1 → o_Valid is 1 for exactly one cycle, one cycle after the strobe, with those values; o_Sel=0.
2. Wrap-around with NUM_CH=8: from Sel=7, i_Next → Sel=0 with a one-cycle o_Sel_Changed pulse. From Sel=0, i_Prev → Sel=7. i_Next and i_Prev together → Sel unchanged and no pulse.
3. Shadow refresh: ch3 strobes 8'h4F while Sel=0, then i_Next is pulsed three times → when Sel becomes 3, o_Valid=1 one cycle later with segments=8'h4F. Stepping onto a never-strobed channel → o_Valid=0.
4. Backpressure: i_Ready=0 while the selected channel strobes A then B → o_Valid stays 1 and the output shows B. Raising i_Ready → a single transfer of B. A new strobe in the same cycle as a transfer → o_Valid stays 1.
5. Auto mode with AUTO_CYCLES=4 and i_Auto_En=1 → Sel advances every 4 cycles. An i_Next coinciding with a tick → exactly one step, and the next auto step follows 4 cycles later.
6. Reset asserted with o_Valid=1 and shadows loaded → next cycle all outputs are 0. Stepping to a previously strobed channel → o_Valid stays 0 (shadows cleared).
